// File: rtl/npc_bpred.sv
// Next-PC generator for the F stage: PC register, direct-mapped BTB with 2-bit
// direction counters, E-stage mispredict recovery and exception/eret/jump arbitration.
module npc_bpred #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          BTB_IDX_W = 3,
  parameter logic [1:0]  CNT_ALLOC = 2'b10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        d_jump_valid,
  input  logic [31:0] d_jump_target,
  input  logic        e_br_valid,
  input  logic [31:0] e_slot_pc,
  input  logic        e_taken,
  input  logic [31:0] e_target,
  input  logic        e_pred_taken,
  input  logic [31:0] e_pred_target,
  output logic [31:0] pc_f,
  output logic [31:0] pc_a4_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_target_f,
  output logic        flush_fd,
  output logic [15:0] mispred_cnt
);

  localparam int N     = 1 << BTB_IDX_W;
  localparam int TAG_W = 32 - BTB_IDX_W - 2;

  logic [31:0]          pc_q, pc_d;
  logic [15:0]          mispred_q, mispred_d;
  logic [N-1:0]         valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [N];
  logic [TAG_W-1:0]     tag_d [N];
  logic [31:0]          tgt_q [N];
  logic [31:0]          tgt_d [N];
  logic [1:0]           cnt_q [N];
  logic [1:0]           cnt_d [N];

  logic [BTB_IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]     tag_f, tag_e;
  logic                 hit_f, hit_e, mis;
  logic [31:0]          corr_pc;

  assign idx_f = pc_q[BTB_IDX_W+1:2];
  assign tag_f = pc_q[31:BTB_IDX_W+2];
  assign idx_e = e_slot_pc[BTB_IDX_W+1:2];
  assign tag_e = e_slot_pc[31:BTB_IDX_W+2];

  // Lookup reads the registered arrays, so training this cycle is seen next cycle.
  assign hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign hit_e         = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign pc_f          = pc_q;
  assign pc_a4_f       = pc_q + 32'd4;
  assign pred_taken_f  = hit_f && cnt_q[idx_f][1];
  assign pred_target_f = hit_f ? tgt_q[idx_f] : pc_a4_f;

  assign mis = e_br_valid &&
               ((e_taken != e_pred_taken) || (e_taken && (e_target != e_pred_target)));
  assign corr_pc     = e_taken ? e_target : (e_slot_pc + 32'd4);
  assign flush_fd    = mis && !eret_req && !exc_req;
  assign mispred_cnt = mispred_q;

  always_comb begin
    pc_d = pc_a4_f;
    if (eret_req)          pc_d = epc;
    else if (exc_req)      pc_d = EXC_VEC;
    else if (mis)          pc_d = corr_pc;
    else if (stall)        pc_d = pc_q;
    else if (d_jump_valid) pc_d = d_jump_target;
    else if (pred_taken_f) pc_d = pred_target_f;
  end

  always_comb begin
    mispred_d = mispred_q;
    if (mis && (mispred_q != 16'hFFFF)) mispred_d = mispred_q + 16'd1;
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (e_br_valid) begin
      if (hit_e) begin
        if (e_taken) begin
          if (cnt_q[idx_e] != 2'b11) cnt_d[idx_e] = cnt_q[idx_e] + 2'd1;
          tgt_d[idx_e] = e_target;
        end else if (cnt_q[idx_e] != 2'b00) begin
          cnt_d[idx_e] = cnt_q[idx_e] - 2'd1;
        end
      end else if (e_taken) begin
        valid_d[idx_e] = 1'b1;
        tag_d[idx_e]   = tag_e;
        tgt_d[idx_e]   = e_target;
        cnt_d[idx_e]   = CNT_ALLOC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      mispred_q <= 16'd0;
      valid_q   <= '0;
      for (int i = 0; i < N; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= 2'b01;
      end
    end else begin
      pc_q      <= pc_d;
      mispred_q <= mispred_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: doc/npc_bpred.md
# npc_bpred

Parametrised next-PC generator with an integrated direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It owns the F-stage PC register and predicts the fetch successor of every delay-slot address. Branches are resolved in E, where the block detects mispredictions, redirects fetch and trains the BTB. Exception entry, `eret` return, D-stage register/absolute jumps and stalls are arbitrated here, so F needs no other PC logic.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value loaded by reset.
- `EXC_VEC`, 32'h0000_4180, exception/interrupt handler entry.
- `BTB_IDX_W`, 3, index width; BTB holds 2**BTB_IDX_W entries (legal range 1..8).
- `CNT_ALLOC`, 2'b10, counter value written when a new entry is allocated.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold PC (D hazard).
- `exc_req` in 1: take interrupt/exception this cycle.
- `eret_req` in 1: return from exception.
- `epc` in 32: return address for `eret_req`.
- `d_jump_valid` in 1: jal/jr/jalr in D, target known.
- `d_jump_target` in 32: its target.
- `e_br_valid` in 1: conditional branch resolved in E (one-cycle pulse per branch).
- `e_slot_pc` in 32: address of that branch's delay slot (branch PC + 4).
- `e_taken` in 1: actual direction.
- `e_target` in 32: actual taken target.
- `e_pred_taken` in 1, `e_pred_target` in 32: prediction carried down the pipe from F.
- `pc_f` out 32: current fetch PC (registered).
- `pc_a4_f` out 32: `pc_f + 4`.
- `pred_taken_f` out 1, `pred_target_f` out 32: prediction for `pc_f`'s successor, to be piped to E.
- `flush_fd` out 1: kill the instruction currently in F (and the one in D if it is past the delay slot).
- `mispred_cnt` out 16: saturating misprediction count.

## Operation
- BTB entry: valid bit, tag `pc[31:BTB_IDX_W+2]`, 32-bit target, 2-bit counter. Index is `pc[BTB_IDX_W+1:2]`.
- Lookup (combinational on `pc_f`): hit = valid && tag match. `pred_taken_f` = hit && counter[1]. `pred_target_f` = entry target when hit, else `pc_f + 4`.
- Mispredict: `mis` = `e_br_valid` && (`e_taken` != `e_pred_taken` || (`e_taken` && `e_target` != `e_pred_target`)). Corrected PC = `e_taken` ? `e_target` : `e_slot_pc + 4`.
- Next-PC priority, highest first:
  - `eret_req` -> `epc`
  - `exc_req` -> `EXC_VEC`
  - `mis` -> corrected PC
  - `stall` -> hold `pc_f`
  - `d_jump_valid` -> `d_jump_target`
  - `pred_taken_f` -> `pred_target_f`
  - otherwise `pc_f + 4`
- Items 1–3 override `stall`. A jump under stall is dropped; D re-presents it.
- `flush_fd` = `mis` && !`eret_req` && !`exc_req`. Exception flushing belongs to the CP0 path.
- Training on every `e_br_valid` (independent of stall/exc/eret):
  - Tag hit: counter saturating +1 if taken, −1 if not. Target overwritten with `e_target` if taken.
  - Miss and taken: allocate (valid=1, tag, target, counter=`CNT_ALLOC`), evicting the current occupant.
  - Miss and not taken: no change.
- `mispred_cnt` increments on each `mis` and saturates at 16'hFFFF.
- All arithmetic is 32-bit modulo 2^32: `pc_f + 4` wraps FFFF_FFFC -> 0000_0000. No alignment checking.

## Timing
- Reset (sync): `pc_f`=`RESET_PC`, all valid bits 0, counters 2'b01, `mispred_cnt`=0. `pred_taken_f`=0, `pred_target_f`=`RESET_PC+4`, `flush_fd`=0. Reset asserted mid-operation wins over every request at that edge.
- `pc_f` changes one cycle after the edge that samples the selected source. Redirect latency is 1 cycle for every source.
- Lookup is read-before-write. A same-cycle update at the index of `pc_f` is visible to `pc_f` values from the next cycle on.
- `flush_fd` is combinational, asserted in the same cycle as `mis`.

## Test plan
- Reset then 3 free-running cycles -> `pc_f` 3000, 3004, 3008, 300C; `pred_taken_f`=0.
- Taken branch, slot 3010 -> 3400 resolved (pred 0) -> `flush_fd`=1, next `pc_f`=3400, `mispred_cnt`=1. Next fetch of 3010 -> `pred_taken_f`=1, target 3400, next `pc_f`=3400.
- Same branch resolved not-taken twice after allocation -> counter 10->01->00. Second resolution with pred 1 mispredicts -> next `pc_f`=3014.
- `stall`=1 with `d_jump_valid` (target 3800) -> `pc_f` held. Stall released -> `pc_f`=3800.
- `exc_req` and `mis` in the same cycle -> `pc_f`=4180, `flush_fd`=0, BTB still trained. `eret_req` with `epc`=3020 and `exc_req` together -> `pc_f`=3020.
- Aliasing: slots 3010 and 3030 with `BTB_IDX_W`=3 (same index, different tag), both taken -> second evicts first. Lookup at 3010 then misses; `pc_f` at FFFF_FFFC with no redirect -> next `pc_f`=0000_0000.
